// File: rtl/pic_ack_sequencer_if.sv
// rtl/pic_ack_sequencer_if.sv - CPU-side INTA/INT/data-bus bundle of the interrupt-acknowledge sequencer
interface pic_ack_sequencer_if;
    logic       INTA_n;
    logic       INT;
    logic [7:0] D_OUT;
    logic       D_EN;

    modport master (
        output INTA_n,
        input  INT,
        input  D_OUT,
        input  D_EN
    );

    modport slave (
        input  INTA_n,
        output INT,
        output D_OUT,
        output D_EN
    );
endinterface

// File: rtl/pic_ack_sequencer.sv
// rtl/pic_ack_sequencer.sv - fixed-priority resolve, INT drive, two-pulse INTA sequencing, EOI/AEOI isr clearing
module pic_ack_sequencer (
    input  logic                clk,
    input  logic                rst_n,
    pic_ack_sequencer_if.slave  bus,
    input  logic [7:0]          irr,
    input  logic [7:0]          imr,
    input  logic [7:0]          icw2,
    input  logic [7:0]          icw4,
    input  logic                eoi_valid,
    input  logic                eoi_specific,
    input  logic [2:0]          eoi_level,
    input  logic                send_vector_address,
    output logic [7:0]          isr,
    output logic [7:0]          irr_clear
);
    typedef enum logic [1:0] {S_IDLE, S_ACK1, S_GAP, S_ACK2} state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_sync_prev;
    logic       w_fall;
    logic       w_rise;
    logic [2:0] r_lvl;
    logic [2:0] w_lvl_nx;
    logic       r_spur;
    logic       w_spur_nx;
    logic       r_int;
    logic       w_int_nx;
    logic [7:0] r_isr;
    logic [7:0] w_isr_nx;
    logic [7:0] r_irr_clear;
    logic [7:0] w_irr_clear_nx;
    logic [7:0] r_dout;
    logic [7:0] w_dout_nx;
    logic       r_den;
    logic       w_den_nx;
    logic [7:0] w_req;
    logic [7:0] w_set;
    logic [7:0] w_eoi_clr;
    logic [7:0] w_aeoi_clr;
    logic [2:0] w_cand;
    logic       w_cand_found;
    logic       w_cand_valid;
    logic       w_unused;

    assign w_unused = ^{icw4[7:2], icw4[0], icw2[2:0]};

    // INTA_n is asynchronous; r_sync_prev is the edge-detector history tap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync1     <= bus.INTA_n;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    assign w_fall = r_sync_prev & ~r_sync2;
    assign w_rise = ~r_sync_prev & r_sync2;
    assign w_req  = irr & ~imr;

    // Fully nested: any in-service level at or above the candidate blocks it
    always_comb begin
        w_cand       = 3'd0;
        w_cand_found = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (w_req[k]) begin
                w_cand       = 3'(k);
                w_cand_found = 1'b1;
            end
        end
        w_cand_valid = w_cand_found;
        for (int j = 0; j < 8; j++) begin
            if ((3'(j) <= w_cand) && r_isr[j]) begin
                w_cand_valid = 1'b0;
            end
        end
    end

    always_comb begin
        w_eoi_clr = 8'h00;
        if (eoi_valid) begin
            if (eoi_specific) begin
                w_eoi_clr = 8'd1 << eoi_level;
            end else begin
                w_eoi_clr = r_isr & (~r_isr + 8'd1);
            end
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_lvl_nx       = r_lvl;
        w_spur_nx      = r_spur;
        w_int_nx       = 1'b0;
        w_irr_clear_nx = 8'h00;
        w_dout_nx      = r_dout;
        w_den_nx       = r_den;
        w_set          = 8'h00;
        w_aeoi_clr     = 8'h00;
        case (r_state)
            S_IDLE: begin
                w_int_nx = w_cand_valid;
                if (w_fall) begin
                    w_state_nx = S_ACK1;
                    w_int_nx   = 1'b0;
                    w_spur_nx  = ~w_cand_valid;
                    if (w_cand_valid) begin
                        w_lvl_nx       = w_cand;
                        w_set          = 8'd1 << w_cand;
                        w_irr_clear_nx = 8'd1 << w_cand;
                    end else begin
                        w_lvl_nx = 3'd7;
                    end
                end
            end
            S_ACK1: begin
                if (w_rise) begin
                    w_state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (w_fall) begin
                    w_state_nx = S_ACK2;
                    if (send_vector_address) begin
                        w_dout_nx = {icw2[7:3], r_lvl};
                        w_den_nx  = 1'b1;
                    end
                end
            end
            S_ACK2: begin
                if (w_rise) begin
                    w_state_nx = S_IDLE;
                    w_den_nx   = 1'b0;
                    if (icw4[1] && !r_spur) begin
                        w_aeoi_clr = 8'd1 << r_lvl;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        // Clears act on the pre-update isr; a same-cycle set overrides them
        w_isr_nx = (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lvl       <= 3'd0;
            r_spur      <= 1'b0;
            r_int       <= 1'b0;
            r_isr       <= 8'h00;
            r_irr_clear <= 8'h00;
            r_dout      <= 8'h00;
            r_den       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_lvl       <= w_lvl_nx;
            r_spur      <= w_spur_nx;
            r_int       <= w_int_nx;
            r_isr       <= w_isr_nx;
            r_irr_clear <= w_irr_clear_nx;
            r_dout      <= w_dout_nx;
            r_den       <= w_den_nx;
        end
    end

    assign bus.INT   = r_int;
    assign bus.D_OUT = r_dout;
    assign bus.D_EN  = r_den;
    assign isr       = r_isr;
    assign irr_clear = r_irr_clear;
endmodule

// File: tb/tb_pic_ack_sequencer.sv
// tb/tb_pic_ack_sequencer.sv - table-driven and scoreboard bench for pic_ack_sequencer
module tb_pic_ack_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irr = 8'h00;
    logic [7:0] imr = 8'h00;
    logic [7:0] icw2 = 8'h00;
    logic [7:0] icw4 = 8'h00;
    logic       eoi_valid = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       send_vector_address = 1'b1;
    logic [7:0] isr;
    logic [7:0] irr_clear;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_vec[$];
    logic [7:0] q_clr[$];
    logic       prev_den = 1'b0;

    pic_ack_sequencer_if bus ();

    pic_ack_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bus                 (bus),
        .irr                 (irr),
        .imr                 (imr),
        .icw2                (icw2),
        .icw4                (icw4),
        .eoi_valid           (eoi_valid),
        .eoi_specific        (eoi_specific),
        .eoi_level           (eoi_level),
        .send_vector_address (send_vector_address),
        .isr                 (isr),
        .irr_clear           (irr_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] irr;
        logic [7:0] imr;
        logic [7:0] icw2;
        logic [7:0] icw4;
        logic       sva;
        logic       exp_int;
        logic [7:0] exp_isr1;
        logic [7:0] exp_clr;
        logic       exp_den;
        logic [7:0] exp_dout;
        logic [7:0] exp_isr_end;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (irr_clear != 8'h00) begin
            if (q_clr.size() == 0) begin
                check("irr_clear_unexpected", irr_clear, 8'h00);
            end else begin
                check("irr_clear_sb", irr_clear, q_clr.pop_front());
            end
        end
        if (bus.D_EN && !prev_den) begin
            if (q_vec.size() == 0) begin
                check("vector_unexpected", 8'(bus.D_EN), 8'h00);
            end else begin
                check("vector_sb", bus.D_OUT, q_vec.pop_front());
            end
        end
        prev_den = bus.D_EN;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic ack1(input string tag, input logic [7:0] exp_isr0,
                        input logic [7:0] exp_isr1, input logic [7:0] exp_clr);
        if (exp_clr != 8'h00) q_clr.push_back(exp_clr);
        bus.INTA_n = 1'b0;
        tick(2);
        check({tag, "_isr_early"}, isr, exp_isr0);
        tick(1);
        check({tag, "_isr_ack1"}, isr, exp_isr1);
        check({tag, "_int_ack1"}, 8'(bus.INT), 8'h00);
        bus.INTA_n = 1'b1;
        tick(4);
    endtask

    task automatic ack2(input string tag, input logic exp_den,
                        input logic [7:0] exp_dout, input logic [7:0] exp_isr_end);
        if (exp_den) q_vec.push_back(exp_dout);
        bus.INTA_n = 1'b0;
        tick(2);
        check({tag, "_den_early"}, 8'(bus.D_EN), 8'h00);
        tick(1);
        check({tag, "_den_ack2"}, 8'(bus.D_EN), 8'(exp_den));
        bus.INTA_n = 1'b1;
        tick(2);
        check({tag, "_den_hold"}, 8'(bus.D_EN), 8'(exp_den));
        tick(1);
        check({tag, "_den_fall"}, 8'(bus.D_EN), 8'h00);
        check({tag, "_isr_end"}, isr, exp_isr_end);
        check({tag, "_dout_hold"}, bus.D_OUT, exp_dout);
        tick(1);
    endtask

    initial begin
        //           irr    imr    icw2   icw4   sva   int   isr1   clr    den   dout   isr_end
        vecs[0] = '{8'h08, 8'h00, 8'h40, 8'h00, 1'b1, 1'b1, 8'h08, 8'h08, 1'b1, 8'h43, 8'h08};
        vecs[1] = '{8'h24, 8'h00, 8'h40, 8'h00, 1'b1, 1'b1, 8'h04, 8'h04, 1'b1, 8'h42, 8'h04};
        vecs[2] = '{8'h01, 8'h00, 8'h88, 8'h02, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 8'h88, 8'h00};
        vecs[3] = '{8'h10, 8'h00, 8'h40, 8'h02, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0, 8'h00, 8'h00};
        vecs[4] = '{8'h02, 8'h02, 8'h40, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h47, 8'h00};
        vecs[5] = '{8'h81, 8'h01, 8'hF8, 8'h00, 1'b1, 1'b1, 8'h80, 8'h80, 1'b1, 8'hFF, 8'h80};

        bus.INTA_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("rst_int", 8'(bus.INT), 8'h00);
        check("rst_isr", isr, 8'h00);
        check("rst_irr_clear", irr_clear, 8'h00);
        check("rst_den", 8'(bus.D_EN), 8'h00);
        check("rst_dout", bus.D_OUT, 8'h00);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            irr  = vecs[i].irr;
            imr  = vecs[i].imr;
            icw2 = vecs[i].icw2;
            icw4 = vecs[i].icw4;
            send_vector_address = vecs[i].sva;
            tick(3);
            check($sformatf("v%0d_int", i), 8'(bus.INT), 8'(vecs[i].exp_int));
            ack1($sformatf("v%0d", i), 8'h00, vecs[i].exp_isr1, vecs[i].exp_clr);
            irr = irr & ~vecs[i].exp_clr;
            ack2($sformatf("v%0d", i), vecs[i].exp_den, vecs[i].exp_dout, vecs[i].exp_isr_end);
        end

        // Nested: IR2 served, IR5 held off until a non-specific EOI
        do_reset();
        imr = 8'h00; icw2 = 8'h40; icw4 = 8'h00; send_vector_address = 1'b1;
        irr = 8'h24;
        tick(3);
        ack1("nest_a", 8'h00, 8'h04, 8'h04);
        irr = 8'h20;
        ack2("nest_a", 1'b1, 8'h42, 8'h04);
        tick(3);
        check("nest_int_blocked", 8'(bus.INT), 8'h00);
        eoi_valid = 1'b1; eoi_specific = 1'b0;
        tick(1);
        eoi_valid = 1'b0;
        check("nest_eoi_isr", isr, 8'h00);
        check("nest_int_lag", 8'(bus.INT), 8'h00);
        tick(1);
        check("nest_int_rise", 8'(bus.INT), 8'h01);
        ack1("nest_b", 8'h00, 8'h20, 8'h20);
        irr = 8'h00;
        ack2("nest_b", 1'b1, 8'h45, 8'h20);

        // Request withdrawn before the first pulse is recognised
        do_reset();
        irr = 8'h08;
        tick(3);
        check("spur_int_pre", 8'(bus.INT), 8'h01);
        irr = 8'h00;
        ack1("spur", 8'h00, 8'h00, 8'h00);
        ack2("spur", 1'b1, 8'h47, 8'h00);
        irr = 8'h08;
        tick(2);
        check("spur_int_reeval", 8'(bus.INT), 8'h01);

        // Specific EOI on level 6 with isr=0x41
        do_reset();
        irr = 8'h40;
        tick(3);
        ack1("spec_a", 8'h00, 8'h40, 8'h40);
        irr = 8'h01;
        ack2("spec_a", 1'b1, 8'h46, 8'h40);
        tick(1);
        ack1("spec_b", 8'h40, 8'h41, 8'h01);
        irr = 8'h00;
        ack2("spec_b", 1'b1, 8'h40, 8'h41);
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd6;
        tick(1);
        eoi_valid = 1'b0;
        check("spec_eoi6", isr, 8'h01);

        // EOI of bit 4 in the same cycle as the ACK1 set of bit 4
        do_reset();
        irr = 8'h10;
        tick(3);
        q_clr.push_back(8'h10);
        bus.INTA_n = 1'b0;
        tick(2);
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd4;
        tick(1);
        eoi_valid = 1'b0;
        check("coll_isr", isr, 8'h10);
        irr = 8'h00;
        bus.INTA_n = 1'b1;
        tick(4);
        ack2("coll", 1'b1, 8'h44, 8'h10);

        // Asynchronous reset while parked in GAP
        irr = 8'h08;
        eoi_valid = 1'b1; eoi_specific = 1'b0;
        tick(1);
        eoi_valid = 1'b0;
        tick(2);
        ack1("rgap", 8'h00, 8'h08, 8'h08);
        #2 rst_n = 1'b0;
        #1;
        check("rgap_int", 8'(bus.INT), 8'h00);
        check("rgap_isr", isr, 8'h00);
        check("rgap_den", 8'(bus.D_EN), 8'h00);
        check("rgap_dout", bus.D_OUT, 8'h00);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("rgap_int_after", 8'(bus.INT), 8'h01);
        ack1("rgap2", 8'h00, 8'h08, 8'h08);
        irr = 8'h00;
        ack2("rgap2", 1'b1, 8'h43, 8'h08);

        tick(2);
        check("sb_vec_drain", 8'(q_vec.size()), 8'h00);
        check("sb_clr_drain", 8'(q_clr.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
